// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - valid/ready pipeline buffer with optional two-entry skid register
module pipe_skid_buf #(
  parameter int unsigned           DATA_W      = 32,
  parameter logic [DATA_W-1:0]     RST_PAYLOAD = DATA_W'(32'h00000013),
  parameter bit                    SKID_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [1:0]        count_o
);

  // State encoding doubles as the held-entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_ready;

  logic [1:0]        w_next_state;
  logic [DATA_W-1:0] w_next_main;
  logic [DATA_W-1:0] w_next_skid;
  logic              w_accept;
  logic              w_pop;

  // Handshake events; ready comes from the output process so both modes share this logic.
  always_comb begin
    w_accept = in_valid_i && in_ready_o;
    w_pop    = out_valid_o && out_ready_i;
  end

  // State and payload registers; skid-mode ready is precomputed from the next state
  // so it never depends combinationally on out_ready_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_main     <= RST_PAYLOAD;
      r_skid     <= RST_PAYLOAD;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_main     <= w_next_main;
      r_skid     <= w_next_skid;
      r_in_ready <= (w_next_state != ST_TWO);
    end
  end

  // Next-state and next-payload selection; flush overrides every handshake.
  always_comb begin
    w_next_state = r_state;
    w_next_main  = r_main;
    w_next_skid  = r_skid;
    if (flush_i) begin
      w_next_state = ST_EMPTY;
      w_next_main  = RST_PAYLOAD;
      w_next_skid  = RST_PAYLOAD;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_next_state = ST_ONE;
            w_next_main  = in_data_i;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_next_main = in_data_i;
          end else if (w_pop) begin
            w_next_state = ST_EMPTY;
            w_next_main  = RST_PAYLOAD;
          end else if (w_accept && SKID_EN) begin
            w_next_state = ST_TWO;
            w_next_skid  = in_data_i;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_next_state = ST_ONE;
            w_next_main  = r_skid;
            w_next_skid  = RST_PAYLOAD;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
          w_next_main  = RST_PAYLOAD;
          w_next_skid  = RST_PAYLOAD;
        end
      endcase
    end
  end

  // Outputs: head register, occupancy and the mode-dependent ready.
  always_comb begin
    out_valid_o = (r_state != ST_EMPTY);
    out_data_o  = r_main;
    count_o     = r_state;
    if (SKID_EN) begin
      in_ready_o = r_in_ready;
    end else begin
      in_ready_o = (r_state == ST_EMPTY) || out_ready_i;
    end
  end

endmodule

// File: doc/pipe_skid_buf.md
PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (must be >= 1).
REQ-002 Parameter RST_PAYLOAD, default 32'h00000013 (NOP), value loaded on reset, on flush and whenever a stage empties.
REQ-003 Parameter SKID_EN, default 1; 1 selects two-entry skid mode with a registered in_ready_o, 0 selects single-entry mode with a combinational in_ready_o.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port flush_i  input  1  synchronous pipeline flush.
REQ-007 Port in_valid_i  input  1  upstream payload valid.
REQ-008 Port in_data_i  input  DATA_W  upstream payload.
REQ-009 Port in_ready_o  output  1  buffer can accept this cycle.
REQ-010 Port out_valid_o  output  1  out_data_o holds a live payload.
REQ-011 Port out_data_o  output  DATA_W  head payload; equals RST_PAYLOAD when empty.
REQ-012 Port out_ready_i  input  1  downstream accepts; low means stall.
REQ-013 Port count_o  output  2  number of held entries (0..2).

Function
REQ-014 An accept occurs when in_valid_i && in_ready_o; a pop occurs when out_valid_o && out_ready_i.
REQ-015 Storage is a main register (head, drives out_data_o) and, in skid mode only, a skid register.
REQ-016 The state machine has three states: EMPTY (count 0), ONE (count 1), TWO (count 2, skid mode only); out_valid_o = (state != EMPTY).
REQ-017 Skid-mode in_ready_o shall be a flop output equal to (state != TWO), with no combinational path from out_ready_i.
REQ-018 Single-entry in_ready_o shall equal (state == EMPTY) || out_ready_i.
REQ-019 EMPTY + accept -> ONE, main <= in_data_i.
REQ-020 ONE + accept + pop -> ONE, main <= in_data_i (zero-bubble throughput).
REQ-021 ONE + pop, no accept -> EMPTY, main <= RST_PAYLOAD.
REQ-022 ONE + accept, no pop (skid mode) -> TWO, skid <= in_data_i, main unchanged.
REQ-023 TWO + pop -> ONE, main <= skid, skid <= RST_PAYLOAD; no accept is possible in TWO.
REQ-024 With no accept and no pop, the state and all registers are held (stall).
REQ-025 Payload order is strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-026 flush_i has priority over all events: next state is EMPTY, main and skid <= RST_PAYLOAD, count_o = 0.
REQ-027 An input presented in a flush cycle is discarded, even if in_ready_o is high.
REQ-028 A pop coinciding with flush is legal; the head payload is still delivered that cycle.
REQ-029 Latency is one cycle from accept to out_valid_o, in both modes.
REQ-030 Sustained throughput is 1 payload/cycle whenever out_ready_i is held high.
REQ-031 count_o is a registered output that matches the state encoding.

Reset
REQ-032 While rst is high, asynchronously: state = EMPTY, main = skid = RST_PAYLOAD, out_valid_o = 0, count_o = 0, out_data_o = RST_PAYLOAD.
REQ-033 While rst is high, in_ready_o = 0 in skid mode; it rises on the first clk edge after rst deasserts.
REQ-034 Asserting rst mid-operation discards all contents immediately, without waiting for a clock edge.

Verification
REQ-035 Streaming: DATA_W=32, SKID_EN=1, out_ready_i=1, push 0x1..0x8 on consecutive cycles -> out_data_o shows 0x1..0x8 one cycle later, back-to-back, count_o stays 1.
REQ-036 Stall into skid: push 0xA then 0xB with out_ready_i=0 -> count_o=2 and in_ready_o=0; release out_ready_i -> pops 0xA then 0xB, then out_data_o=0x00000013.
REQ-037 Flush: from TWO, assert flush_i with in_valid_i=1 and in_data_i=0xC -> next cycle count_o=0, out_valid_o=0, out_data_o=0x00000013, and 0xC never appears.
REQ-038 Async reset: assert rst between clock edges while in ONE -> out_valid_o falls before the next edge.
REQ-039 SKID_EN=0: hold out_ready_i=0 after one push -> in_ready_o=0 in the same cycle; raise out_ready_i -> in_ready_o=1 combinationally, and accept plus pop occur in the same cycle.
REQ-040 Random valid/ready, 10k cycles, both modes: scoreboard confirms in-order, lossless delivery and count_o matching the model.
